// File: rtl/div_pkg.sv
// Shared constants and state encoding for the divider recomposition block.
package div_pkg;
  localparam int DW = 8;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_e;
endpackage

// File: rtl/div_recompose_dp.sv
// Datapath: operand registers, shift-add accumulator, iteration counter and
// absolute-difference unit feeding the registered result outputs.
module div_recompose_dp
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            capture,
  input  logic [2*DW-1:0] x,
  input  logic [DW-1:0]   y,
  input  logic [DW-1:0]   q,
  input  logic [DW-1:0]   r,
  output logic            last,
  output logic [2*DW-1:0] diff,
  output logic            diff_zero,
  output logic            y_zero,
  output logic [2*DW-1:0] recon,
  output logic [2*DW-1:0] err_dist,
  output logic            exact,
  output logic            div_zero
);
  logic [2*DW-1:0] x_q;
  logic [DW-1:0]   y_q;
  logic [DW-1:0]   q_q;
  logic [2*DW-1:0] acc;
  logic [CW-1:0]   i_q;
  logic [2*DW-1:0] addend;

  always_comb begin
    last      = (i_q == CW'(DW - 1));
    diff      = (x_q >= acc) ? (x_q - acc) : (acc - x_q);
    diff_zero = (diff == '0);
    y_zero    = (y_q == '0);
    addend    = q_q[i_q] ? ({{DW{1'b0}}, y_q} << i_q) : '0;
  end

  // acc starts at r so the final sum is q*y + r without a separate add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      q_q      <= '0;
      acc      <= '0;
      i_q      <= '0;
      recon    <= '0;
      err_dist <= '0;
      exact    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (load) begin
        x_q <= x;
        y_q <= y;
        q_q <= q;
        acc <= {{DW{1'b0}}, r};
        i_q <= '0;
      end else if (step) begin
        acc <= acc + addend;
        i_q <= i_q + CW'(1);
      end
      if (capture) begin
        recon    <= acc;
        err_dist <= diff;
        exact    <= diff_zero;
        div_zero <= y_zero;
      end
    end
  end
endmodule

// File: rtl/div_recompose.sv
// Recomposes q*y + r, measures |x - recon| and keeps error statistics.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module div_recompose
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] x,
  input  logic [DW-1:0]   y,
  input  logic [DW-1:0]   q,
  input  logic [DW-1:0]   r,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] recon,
  output logic [2*DW-1:0] err_dist,
  output logic            exact,
  output logic            div_zero,
  input  logic            stat_clr,
  output logic [15:0]     err_count,
  output logic [2*DW-1:0] err_max,
  output state_e          dbg_state
);
  state_e          state_q, state_d;
  logic            accept;
  logic            last;
  logic [2*DW-1:0] diff;
  logic            diff_zero;
  logic            y_zero;
  logic            stat_upd;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;
  assign stat_upd  = (state_q == CMP) && !diff_zero && !y_zero;

  div_recompose_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (state_q == MUL),
    .capture   (state_q == CMP),
    .x         (x),
    .y         (y),
    .q         (q),
    .r         (r),
    .last      (last),
    .diff      (diff),
    .diff_zero (diff_zero),
    .y_zero    (y_zero),
    .recon     (recon),
    .err_dist  (err_dist),
    .exact     (exact),
    .div_zero  (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (last) state_d = CMP;
      CMP:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else if (state_q == CMP) out_valid <= 1'b1;
    else if (state_q == DONE && out_ready) out_valid <= 1'b0;
  end

  // A clear on the same edge as an update wins; that result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (stat_clr) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (stat_upd) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (diff > err_max) err_max <= diff;
    end
  end
endmodule

// File: tb/tb_div_recompose.sv
// Directed bench for div_recompose: arithmetic model, per-cycle output compare,
// handshake timing, statistics, mid-operation reset and clear priority.
module tb_div_recompose;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [7:0]  y = '0;
  logic [7:0]  q = '0;
  logic [7:0]  r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] recon;
  logic [15:0] err_dist;
  logic        exact;
  logic        div_zero;
  logic        stat_clr = 1'b0;
  logic [15:0] err_count;
  logic [15:0] err_max;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected entry: {clr, div_zero, exact, err_dist[15:0], recon[15:0]}
  logic [34:0] exp_q[$];
  logic [15:0] m_cnt;
  logic [15:0] m_max;

  div_recompose dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .q(q), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .recon(recon), .err_dist(err_dist), .exact(exact), .div_zero(div_zero),
    .stat_clr(stat_clr), .err_count(err_count), .err_max(err_max),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] model(input logic [15:0] xv, input logic [7:0] yv,
                                        input logic [7:0] qv, input logic [7:0] rv,
                                        input logic clr);
    int rc;
    int e;
    rc = int'(qv) * int'(yv) + int'(rv);
    e  = (int'(xv) >= rc) ? int'(xv) - rc : rc - int'(xv);
    return {clr, (yv == 8'd0), (e == 0), e[15:0], rc[15:0]};
  endfunction

  // Compare process: checks every cycle a result is presented.
  logic        seen = 1'b0;
  logic [34:0] cur = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen  = 1'b0;
      m_cnt = '0;
      m_max = '0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got a result, expected none (t=%0t)", $time);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        if (cur[34]) begin
          m_cnt = '0;
          m_max = '0;
        end else if (!cur[33] && !cur[32]) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (cur[31:16] > m_max) m_max = cur[31:16];
        end
      end
      chk("recon", 32'(recon), 32'(cur[15:0]));
      chk("err_dist", 32'(err_dist), 32'(cur[31:16]));
      chk("exact", 32'(exact), 32'(cur[32]));
      chk("div_zero", 32'(div_zero), 32'(cur[33]));
      chk("err_count", 32'(err_count), 32'(m_cnt));
      chk("err_max", 32'(err_max), 32'(m_max));
    end else begin
      seen = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one sample; optionally hold the result for 'hold' cycles with a
  // competing in_valid, and optionally pulse stat_clr on the compute edge.
  task automatic send(input logic [15:0] xv, input logic [7:0] yv, input logic [7:0] qv,
                      input logic [7:0] rv, input int hold, input bit clr);
    int lat;
    wait_ready();
    x = xv; y = yv; q = qv; r = rv;
    in_valid = 1'b1;
    exp_q.push_back(model(xv, yv, qv, rv, clr));
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'hDEAD; q = 8'hAA; r = 8'h55;
    chk("busy_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      if (clr && lat == DW) stat_clr = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    stat_clr = 1'b0;
    // out_valid appears after the compute edge, DW+1 edges past acceptance.
    chk("latency", 32'(lat), 32'(DW + 1));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      x = 16'h1234; y = 8'd3; q = 8'd9; r = 8'd1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_out_valid", 32'(out_valid), 32'd0);
    chk("released_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Pin the model with hand-computed values.
    begin
      logic [34:0] m;
      m = model(16'd1000, 8'd7, 8'd142, 8'd2, 1'b0);
      chk("model_recon", 32'(m[15:0]), 32'd996);
      chk("model_err", 32'(m[31:16]), 32'd4);
      m = model(16'd9, 8'd0, 8'd255, 8'd5, 1'b0);
      chk("model_dz_recon", 32'(m[15:0]), 32'd5);
      chk("model_dz_flag", 32'(m[33]), 32'd1);
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_recon", 32'(recon), 32'd0);
    chk("rst_err_dist", 32'(err_dist), 32'd0);
    chk("rst_exact", 32'(exact), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_max", 32'(err_max), 32'd0);

    send(16'd1000, 8'd7, 8'd142, 8'd6, 0, 1'b0);
    chk("exact_count", 32'(err_count), 32'd0);
    send(16'd1000, 8'd7, 8'd142, 8'd2, 0, 1'b0);
    chk("inexact1_count", 32'(err_count), 32'd1);
    chk("inexact1_max", 32'(err_max), 32'd4);
    chk("inexact1_recon", 32'(recon), 32'd996);
    send(16'd1000, 8'd7, 8'd141, 8'd6, 0, 1'b0);
    chk("inexact2_recon", 32'(recon), 32'd993);
    chk("inexact2_count", 32'(err_count), 32'd2);
    chk("inexact2_max", 32'(err_max), 32'd7);
    send(16'd65280, 8'd255, 8'd255, 8'd255, 0, 1'b0);
    chk("maxw_recon", 32'(recon), 32'd65280);
    chk("maxw_exact", 32'(exact), 32'd1);
    send(16'd9, 8'd0, 8'd255, 8'd5, 0, 1'b0);
    chk("dz_err", 32'(err_dist), 32'd4);
    chk("dz_count", 32'(err_count), 32'd2);
    chk("dz_max", 32'(err_max), 32'd7);
    send(16'd500, 8'd10, 8'd40, 8'd3, 5, 1'b0);
    chk("hold_recon", 32'(recon), 32'd403);
    chk("hold_max", 32'(err_max), 32'd97);
    send(16'd100, 8'd3, 8'd30, 8'd5, 0, 1'b0);
    chk("small_count", 32'(err_count), 32'd4);
    chk("small_max_kept", 32'(err_max), 32'd97);

    // Reset during MUL iteration 4.
    wait_ready();
    x = 16'd777; y = 8'd9; q = 8'd80; r = 8'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_count", 32'(err_count), 32'd0);
    chk("abort_max", 32'(err_max), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end

    send(16'd1000, 8'd7, 8'd142, 8'd2, 0, 1'b1);
    chk("clr_wins_count", 32'(err_count), 32'd0);
    chk("clr_wins_max", 32'(err_max), 32'd0);
    send(16'd1000, 8'd7, 8'd142, 8'd0, 0, 1'b0);
    chk("post_clr_count", 32'(err_count), 32'd1);
    chk("post_clr_max", 32'(err_max), 32'd6);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
